// File: rtl/zsdram_access_scheduler_if.sv
// Bus bundle between the access scheduler, its write/read requesters and the SDRAM function module.
// The master side is the scheduler; the slave side is everything around it.
interface zsdram_access_scheduler_if;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        init_done;
    logic        ref_overrun;
    logic [3:0]  call;
    logic [23:0] call_addr;
    logic [15:0] call_wdata;
    logic        call_done;
    logic [15:0] call_rdata;

    modport master (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, call_done, call_rdata,
        output wr_ack, rd_data, rd_valid, init_done, ref_overrun, call, call_addr, call_wdata
    );

    modport slave (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, call_done, call_rdata,
        input  wr_ack, rd_data, rd_valid, init_done, ref_overrun, call, call_addr, call_wdata
    );
endinterface

// File: rtl/zsdram_access_scheduler.sv
// Sequences the SDRAM function module: power-on init, periodic auto-refresh, and round-robin
// arbitration of one write port and one read port onto a one-hot call that is held until done.
module zsdram_access_scheduler #(
    parameter logic [15:0] REF_INTERVAL = 16'd1030,
    parameter int          REF_CNT_W    = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    zsdram_access_scheduler_if.master        bus
);
    localparam logic [3:0] CALL_INIT = 4'b0001;
    localparam logic [3:0] CALL_REF  = 4'b0010;
    localparam logic [3:0] CALL_RD   = 4'b0100;
    localparam logic [3:0] CALL_WR   = 4'b1000;
    localparam logic [REF_CNT_W-1:0] REF_LAST = REF_CNT_W'(REF_INTERVAL - 16'd1);

    typedef enum logic [2:0] {
        S_INIT_ISSUE, S_INIT_WAIT, S_IDLE, S_REF, S_WR, S_RD, S_GAP
    } state_t;

    state_t               state, state_n;
    logic [3:0]           call_q, call_n;
    logic [23:0]          addr_q, addr_n;
    logic [15:0]          wdata_q, wdata_n;
    logic [15:0]          rdata_q, rdata_n;
    logic                 wr_ack_q, wr_ack_n;
    logic                 rd_valid_q, rd_valid_n;
    logic                 init_done_q, init_done_n;
    logic                 overrun_q, overrun_n;
    logic [REF_CNT_W-1:0] ref_cnt, ref_cnt_n;
    logic                 ref_pend, ref_pend_n;
    logic                 last_rd, last_rd_n;
    logic                 ref_done;
    logic                 ref_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_INIT_ISSUE;
            call_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wr_ack_q    <= 1'b0;
            rd_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            overrun_q   <= 1'b0;
            ref_cnt     <= '0;
            ref_pend    <= 1'b0;
            last_rd     <= 1'b1;
        end else begin
            state       <= state_n;
            call_q      <= call_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            rdata_q     <= rdata_n;
            wr_ack_q    <= wr_ack_n;
            rd_valid_q  <= rd_valid_n;
            init_done_q <= init_done_n;
            overrun_q   <= overrun_n;
            ref_cnt     <= ref_cnt_n;
            ref_pend    <= ref_pend_n;
            last_rd     <= last_rd_n;
        end
    end

    // call_done only matters while a call is outstanding; the function module idles with done high
    always_comb begin
        state_n     = state;
        call_n      = call_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        rdata_n     = rdata_q;
        wr_ack_n    = 1'b0;
        rd_valid_n  = 1'b0;
        init_done_n = init_done_q;
        overrun_n   = overrun_q;
        ref_cnt_n   = ref_cnt;
        ref_pend_n  = ref_pend;
        last_rd_n   = last_rd;
        ref_done    = 1'b0;
        ref_wrap    = init_done_q && (ref_cnt == REF_LAST);

        case (state)
            S_INIT_ISSUE: begin
                call_n  = CALL_INIT;
                state_n = S_INIT_WAIT;
            end
            S_INIT_WAIT, S_REF, S_WR, S_RD: begin
                if (bus.call_done) begin
                    call_n  = '0;
                    state_n = S_GAP;
                    if (state == S_INIT_WAIT) init_done_n = 1'b1;
                    if (state == S_REF)       ref_done    = 1'b1;
                    if (state == S_WR)        wr_ack_n    = 1'b1;
                    if (state == S_RD) begin
                        rdata_n    = bus.call_rdata;
                        rd_valid_n = 1'b1;
                    end
                end
            end
            S_GAP: state_n = S_IDLE;
            S_IDLE: begin
                if (ref_pend) begin
                    call_n  = CALL_REF;
                    state_n = S_REF;
                end else if (bus.wr_req && (!bus.rd_req || last_rd)) begin
                    call_n    = CALL_WR;
                    addr_n    = bus.wr_addr;
                    wdata_n   = bus.wr_data;
                    last_rd_n = 1'b0;
                    state_n   = S_WR;
                end else if (bus.rd_req) begin
                    call_n    = CALL_RD;
                    addr_n    = bus.rd_addr;
                    last_rd_n = 1'b1;
                    state_n   = S_RD;
                end
            end
            default: begin
                call_n  = '0;
                state_n = S_INIT_ISSUE;
            end
        endcase

        // A wrap that lands on a still-pending refresh is an overrun; only one refresh is owed
        if (init_done_q) ref_cnt_n = ref_wrap ? '0 : ref_cnt + 1'b1;
        if (ref_wrap) begin
            ref_pend_n = 1'b1;
            if (ref_pend) overrun_n = 1'b1;
        end else if (ref_done) begin
            ref_pend_n = 1'b0;
        end
    end

    assign bus.call        = call_q;
    assign bus.call_addr   = addr_q;
    assign bus.call_wdata  = wdata_q;
    assign bus.rd_data     = rdata_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.init_done   = init_done_q;
    assign bus.ref_overrun = overrun_q;
endmodule

// File: tb/tb_zsdram_access_scheduler.sv
// Scoreboard bench for zsdram_access_scheduler: a behavioural function-module model answers calls,
// the main thread queues expected call/ack/valid events and a monitor pops and compares them.
module tb_zsdram_access_scheduler;
    localparam logic [3:0] C_INIT = 4'b0001;
    localparam logic [3:0] C_REF  = 4'b0010;
    localparam logic [3:0] C_RD   = 4'b0100;
    localparam logic [3:0] C_WR   = 4'b1000;

    typedef enum logic [1:0] {EV_CALL, EV_WACK, EV_RVAL} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [3:0]  call;
        bit          chk_addr;
        logic [23:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          cycle = 0;
    int          done_delay = 20;
    logic        idle_done = 1'b1;
    logic [15:0] model_rdata = 16'h0000;

    zsdram_access_scheduler_if bus();

    zsdram_access_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Function-module model: done pulses after done_delay cycles of a visible call, high when idle
    initial begin
        int cnt;
        cnt = 0;
        bus.call_done  = 1'b1;
        bus.call_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            bus.call_rdata = model_rdata;
            if (bus.call === 4'b0000) begin
                cnt = 0;
                bus.call_done = idle_done;
            end else begin
                cnt++;
                bus.call_done = (cnt == done_delay);
            end
        end
    end

    function automatic ev_t mkEv(input ev_kind_t k, input logic [3:0] c, input bit ca,
                                 input logic [23:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k; e.call = c; e.chk_addr = ca; e.addr = a; e.data = d;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic checkRange(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    task automatic applyStimulus(input bit do_wr, input bit do_rd, input logic [23:0] wa,
                                 input logic [15:0] wd, input logic [23:0] ra, input int n_done);
        int seen;
        int guard;
        seen  = 0;
        guard = 0;
        bus.wr_req  = do_wr;
        bus.wr_addr = wa;
        bus.wr_data = wd;
        bus.rd_req  = do_rd;
        bus.rd_addr = ra;
        while (seen < n_done && guard < 500) begin
            @(negedge clk);
            guard++;
            if (bus.wr_ack === 1'b1) seen++;
            if (bus.rd_valid === 1'b1) seen++;
        end
        checkOutput("op_completions", seen, n_done);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
    endtask

    // Monitor: every new call, wr_ack and rd_valid must match the head of the expectation queue
    initial begin
        logic [3:0] prev_call;
        logic       prev_wack;
        logic       prev_rval;
        ev_t        e;
        prev_call = 4'b0000;
        prev_wack = 1'b0;
        prev_rval = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.call !== 4'b0000 && prev_call === 4'b0000) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL call_unexpected: got call=%b addr=%h, expected none", bus.call, bus.call_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_CALL || bus.call !== e.call || !$onehot(bus.call) ||
                        (e.chk_addr && bus.call_addr !== e.addr) ||
                        (e.call == C_WR && bus.call_wdata !== e.data)) begin
                        errors++;
                        $display("[TB] FAIL call_event: got call=%b addr=%h wdata=%h expected kind=%0d call=%b addr=%h wdata=%h",
                                 bus.call, bus.call_addr, bus.call_wdata, e.kind, e.call, e.addr, e.data);
                    end
                end
            end
            if (bus.call !== 4'b0000 && prev_call !== 4'b0000 && bus.call !== prev_call) begin
                checks++;
                errors++;
                $display("[TB] FAIL call_changed: got %b expected %b", bus.call, prev_call);
            end
            if (bus.wr_ack === 1'b1) begin
                checks++;
                if (prev_wack === 1'b1) begin
                    errors++;
                    $display("[TB] FAIL wr_ack_width: got 2+ cycles expected 1");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wr_ack_unexpected: got wr_ack expected none");
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_WACK) begin
                        errors++;
                        $display("[TB] FAIL wr_ack_event: got wr_ack expected kind=%0d call=%b", e.kind, e.call);
                    end
                end
            end
            if (bus.rd_valid === 1'b1) begin
                checks++;
                if (prev_rval === 1'b1) begin
                    errors++;
                    $display("[TB] FAIL rd_valid_width: got 2+ cycles expected 1");
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rd_valid_unexpected: got rd_data=%h expected none", bus.rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != EV_RVAL || bus.rd_data !== e.data) begin
                        errors++;
                        $display("[TB] FAIL rd_valid_event: got rd_data=%h expected kind=%0d data=%h",
                                 bus.rd_data, e.kind, e.data);
                    end
                end
            end
            prev_call = bus.call;
            prev_wack = bus.wr_ack;
            prev_rval = bus.rd_valid;
        end
    end

    initial begin
        int n;
        int guard;
        int t_init;
        int t_ref1;
        int t_ref2;
        int p_wrap;
        bus.wr_req  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.wr_addr = 24'h0;
        bus.wr_data = 16'h0;
        bus.rd_addr = 24'h0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_call", bus.call, 4'b0000);
        checkOutput("rst_call_addr", bus.call_addr, 24'h0);
        checkOutput("rst_call_wdata", bus.call_wdata, 16'h0);
        checkOutput("rst_init_done", bus.init_done, 1'b0);
        checkOutput("rst_wr_ack", bus.wr_ack, 1'b0);
        checkOutput("rst_rd_valid", bus.rd_valid, 1'b0);
        checkOutput("rst_rd_data", bus.rd_data, 16'h0);
        checkOutput("rst_overrun", bus.ref_overrun, 1'b0);

        // Power-on init with a 20-cycle done
        done_delay = 20;
        exp_q.push_back(mkEv(EV_CALL, C_INIT, 1'b0, 24'h0, 16'h0));
        rst = 1'b0;
        guard = 0;
        while (bus.call !== C_INIT && guard < 10) begin @(negedge clk); guard++; end
        n = 0;
        while (bus.call === C_INIT && n < 100) begin n++; @(negedge clk); end
        checkOutput("init_call_cycles", n, 20);
        checkOutput("init_done_after", bus.init_done, 1'b1);
        checkOutput("init_call_cleared", bus.call, 4'b0000);
        t_init = cycle;

        // Single write, single read, then alternating W/R with both requests held
        done_delay = 3;
        exp_q.push_back(mkEv(EV_CALL, C_WR, 1'b1, 24'h123456, 16'hBEEF));
        exp_q.push_back(mkEv(EV_WACK, 4'b0000, 1'b0, 24'h0, 16'h0));
        applyStimulus(1'b1, 1'b0, 24'h123456, 16'hBEEF, 24'h0, 1);

        model_rdata = 16'hA5C3;
        exp_q.push_back(mkEv(EV_CALL, C_RD, 1'b1, 24'h0ABCDE, 16'h0));
        exp_q.push_back(mkEv(EV_RVAL, 4'b0000, 1'b0, 24'h0, 16'hA5C3));
        applyStimulus(1'b0, 1'b1, 24'h0, 16'h0, 24'h0ABCDE, 1);

        model_rdata = 16'h1234;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(mkEv(EV_CALL, C_WR, 1'b1, 24'h000010, 16'h5A5A));
            exp_q.push_back(mkEv(EV_WACK, 4'b0000, 1'b0, 24'h0, 16'h0));
            exp_q.push_back(mkEv(EV_CALL, C_RD, 1'b1, 24'h000020, 16'h0));
            exp_q.push_back(mkEv(EV_RVAL, 4'b0000, 1'b0, 24'h0, 16'h1234));
        end
        applyStimulus(1'b1, 1'b1, 24'h000010, 16'h5A5A, 24'h000020, 4);

        // Refresh timing: first call 1031 cycles after init_done, then every 1030
        exp_q.push_back(mkEv(EV_CALL, C_REF, 1'b0, 24'h0, 16'h0));
        guard = 0;
        while (bus.call !== C_REF && guard < 1200) begin @(negedge clk); guard++; end
        t_ref1 = cycle;
        checkRange("ref1_delay", t_ref1 - t_init, 1031, 1032);
        exp_q.push_back(mkEv(EV_CALL, C_REF, 1'b0, 24'h0, 16'h0));
        guard = 0;
        while (bus.call !== 4'b0000 && guard < 50) begin @(negedge clk); guard++; end
        guard = 0;
        while (bus.call !== C_REF && guard < 1200) begin @(negedge clk); guard++; end
        t_ref2 = cycle;
        checkOutput("ref_period", t_ref2 - t_ref1, 1030);

        // Write request arrives in the very cycle ref_pend rises: refresh goes first
        p_wrap = t_ref2 + 1029;
        guard = 0;
        while (cycle < p_wrap && guard < 1200) begin @(negedge clk); guard++; end
        exp_q.push_back(mkEv(EV_CALL, C_REF, 1'b0, 24'h0, 16'h0));
        exp_q.push_back(mkEv(EV_CALL, C_WR, 1'b1, 24'h00ABCD, 16'h7777));
        exp_q.push_back(mkEv(EV_WACK, 4'b0000, 1'b0, 24'h0, 16'h0));
        applyStimulus(1'b1, 1'b0, 24'h00ABCD, 16'h7777, 24'h0, 1);

        // Stalled write starves refresh into overrun, then reset mid-write
        checkOutput("overrun_clear", bus.ref_overrun, 1'b0);
        done_delay = 2100;
        exp_q.push_back(mkEv(EV_CALL, C_WR, 1'b1, 24'h3FFFFF, 16'hFFFF));
        bus.wr_addr = 24'h3FFFFF;
        bus.wr_data = 16'hFFFF;
        bus.wr_req  = 1'b1;
        guard = 0;
        while (bus.call !== C_WR && guard < 20) begin @(negedge clk); guard++; end
        repeat (2080) @(negedge clk);
        checkOutput("overrun_set", bus.ref_overrun, 1'b1);
        checkOutput("stall_call_held", bus.call, C_WR);

        rst = 1'b1;
        bus.wr_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_call", bus.call, 4'b0000);
        checkOutput("rst_mid_init_done", bus.init_done, 1'b0);
        checkOutput("rst_mid_overrun", bus.ref_overrun, 1'b0);
        checkOutput("rst_mid_wr_ack", bus.wr_ack, 1'b0);
        done_delay = 20;
        exp_q.push_back(mkEv(EV_CALL, C_INIT, 1'b0, 24'h0, 16'h0));
        rst = 1'b0;
        guard = 0;
        while (bus.init_done !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
        checkOutput("reinit_done", bus.init_done, 1'b1);

        repeat (5) @(negedge clk);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
